// File: rtl/bank_pkg.sv
// ============================================================================
// bank_pkg: shared status codes, FSM states and operation codes for bank blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package bank_pkg;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'b00,
    STATUS_BAD_DST  = 2'b01,
    STATUS_OVERFLOW = 2'b10,
    STATUS_ZERO_AMT = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SHOW_BALANCE = 2'd0,
    OP_WITHDRAW     = 2'd1,
    OP_TRANSFER     = 2'd2
  } op_e;

endpackage

`default_nettype wire

// File: rtl/bank_credit_check.sv
// ============================================================================
// bank_credit_check: combinational credit validation and new-balance sum
// Rev 1.0
// ============================================================================
`default_nettype none

module bank_credit_check
  import bank_pkg::*;
#(
  parameter logic [7:0]  ACCOUNT_ID  = 8'h01,
  parameter logic [31:0] MAX_BALANCE = 32'hFFFF_FFFF
) (
  input  logic [31:0] balance,
  input  logic [31:0] amount,
  input  logic [7:0]  dst,
  output status_e     status,
  output logic [31:0] sum
);

  logic [32:0] sum_wide;

  // One extra bit so the overflow test also catches a wrap past 2^32
  assign sum_wide = {1'b0, balance} + {1'b0, amount};
  assign sum      = sum_wide[31:0];

  always_comb begin
    status = STATUS_OK;
    if (dst != ACCOUNT_ID) begin
      status = STATUS_BAD_DST;
    end else if (amount == 32'd0) begin
      status = STATUS_ZERO_AMT;
    end else if (sum_wide > {1'b0, MAX_BALANCE}) begin
      status = STATUS_OVERFLOW;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bank_deposit_receiver.sv
// ============================================================================
// bank_deposit_receiver: accepts credit transfers for one account, responds
// with a status and updates the registered balance. Rev 1.0
// ============================================================================
`default_nettype none

module bank_deposit_receiver
  import bank_pkg::*;
#(
  parameter logic [7:0]  ACCOUNT_ID   = 8'h01,
  parameter logic [31:0] INIT_BALANCE = 32'd100000,
  parameter logic [31:0] MAX_BALANCE  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_src_id,
  input  logic [7:0]  req_dst_id,
  input  logic [31:0] req_amount,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_status,
  output logic [31:0] balance,
  output logic [31:0] transaction_log,
  output logic [7:0]  last_src_id,
  output logic [15:0] credit_count
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  status_e     status_q, status_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dst_q, dst_d;
  logic [31:0] amount_q, amount_d;
  logic [31:0] balance_q, balance_d;
  logic [31:0] log_q, log_d;
  logic [7:0]  last_src_q, last_src_d;
  logic [15:0] credit_count_q, credit_count_d;

  status_e     chk_status;
  logic [31:0] chk_sum;

  bank_credit_check #(
    .ACCOUNT_ID  (ACCOUNT_ID),
    .MAX_BALANCE (MAX_BALANCE)
  ) u_credit_check (
    .balance (balance_q),
    .amount  (amount_q),
    .dst     (dst_q),
    .status  (chk_status),
    .sum     (chk_sum)
  );

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    status_d       = status_q;
    src_d          = src_q;
    dst_d          = dst_q;
    amount_d       = amount_q;
    balance_d      = balance_q;
    log_d          = log_q;
    last_src_d     = last_src_q;
    credit_count_d = credit_count_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          src_d       = req_src_id;
          dst_d       = req_dst_id;
          amount_d    = req_amount;
          req_ready_d = 1'b0;
          state_d     = CHECK;
        end
      end
      CHECK: begin
        status_d     = chk_status;
        resp_valid_d = 1'b1;
        state_d      = RESP;
        if (chk_status == STATUS_OK) begin
          balance_d      = chk_sum;
          log_d          = amount_q;
          last_src_d     = src_q;
          credit_count_d = credit_count_q + 16'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      status_q       <= STATUS_OK;
      src_q          <= 8'd0;
      dst_q          <= 8'd0;
      amount_q       <= 32'd0;
      balance_q      <= INIT_BALANCE;
      log_q          <= 32'd0;
      last_src_q     <= 8'd0;
      credit_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      status_q       <= status_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      amount_q       <= amount_d;
      balance_q      <= balance_d;
      log_q          <= log_d;
      last_src_q     <= last_src_d;
      credit_count_q <= credit_count_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_status     = status_q;
  assign balance         = balance_q;
  assign transaction_log = log_q;
  assign last_src_id     = last_src_q;
  assign credit_count    = credit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bank_deposit_receiver.sv
// ============================================================================
// tb_bank_deposit_receiver: directed self-checking bench, default account plus
// a near-full account instance. Rev 1.0
// ============================================================================
`default_nettype none

module tb_bank_deposit_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0]  req_src_id, req_dst_id, last_src_id;
  logic [31:0] req_amount, balance, transaction_log;
  logic [1:0]  resp_status;
  logic [15:0] credit_count;

  logic        req_valid_h, req_ready_h, resp_valid_h, resp_ready_h;
  logic [7:0]  req_src_id_h, req_dst_id_h, last_src_id_h;
  logic [31:0] req_amount_h, balance_h, transaction_log_h;
  logic [1:0]  resp_status_h;
  logic [15:0] credit_count_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bank_deposit_receiver dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_id(req_src_id), .req_dst_id(req_dst_id), .req_amount(req_amount),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .balance(balance), .transaction_log(transaction_log),
    .last_src_id(last_src_id), .credit_count(credit_count)
  );

  bank_deposit_receiver #(.INIT_BALANCE(32'hFFFF_FF00)) dut_hi (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_h), .req_ready(req_ready_h),
    .req_src_id(req_src_id_h), .req_dst_id(req_dst_id_h), .req_amount(req_amount_h),
    .resp_valid(resp_valid_h), .resp_ready(resp_ready_h), .resp_status(resp_status_h),
    .balance(balance_h), .transaction_log(transaction_log_h),
    .last_src_id(last_src_id_h), .credit_count(credit_count_h)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake a request; returns edges from handshake to resp_valid and the status
  task automatic send(input bit hi, input logic [7:0] src, input logic [7:0] dst,
                      input logic [31:0] amt, output int lat, output logic [1:0] st);
    @(negedge clk);
    if (hi) begin
      req_valid_h = 1'b1; req_src_id_h = src; req_dst_id_h = dst; req_amount_h = amt;
    end else begin
      req_valid = 1'b1; req_src_id = src; req_dst_id = dst; req_amount = amt;
    end
    @(posedge clk); #1;
    req_valid   = 1'b0;
    req_valid_h = 1'b0;
    lat = 1;
    while (!(hi ? resp_valid_h : resp_valid) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    st = hi ? resp_status_h : resp_status;
  endtask

  task automatic ack(input bit hi);
    @(negedge clk);
    if (hi) resp_ready_h = 1'b1; else resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready   = 1'b0;
    resp_ready_h = 1'b0;
    check_eq("ack_ready", {31'd0, hi ? req_ready_h : req_ready}, 32'd1);
  endtask

  int         lat;
  logic [1:0] st;

  initial begin
    reset = 1'b1;
    req_valid = 0; resp_ready = 0; req_src_id = 0; req_dst_id = 0; req_amount = 0;
    req_valid_h = 0; resp_ready_h = 0; req_src_id_h = 0; req_dst_id_h = 0; req_amount_h = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_balance", balance, 32'd100000);
    check_eq("rst_log", transaction_log, 32'd0);
    check_eq("rst_src", {24'd0, last_src_id}, 32'd0);
    check_eq("rst_count", {16'd0, credit_count}, 32'd0);
    check_eq("rst_status", {30'd0, resp_status}, 32'd0);
    check_eq("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_balance_hi", balance_h, 32'hFFFF_FF00);

    send(0, 8'h11, 8'h07, 32'd500, lat, st);
    check_eq("baddst_status", {30'd0, st}, 32'd1);
    check_eq("baddst_balance", balance, 32'd100000);
    check_eq("baddst_count", {16'd0, credit_count}, 32'd0);
    ack(0);

    send(0, 8'h11, 8'h01, 32'd0, lat, st);
    check_eq("zero_status", {30'd0, st}, 32'd3);
    check_eq("zero_balance", balance, 32'd100000);
    check_eq("zero_log", transaction_log, 32'd0);
    ack(0);

    send(0, 8'h11, 8'h07, 32'd0, lat, st);
    check_eq("prio_status", {30'd0, st}, 32'd1);
    ack(0);

    send(0, 8'h22, 8'h01, 32'd500, lat, st);
    check_eq("ok_latency", lat, 32'd2);
    check_eq("ok_status", {30'd0, st}, 32'd0);
    check_eq("ok_balance", balance, 32'd100500);
    check_eq("ok_log", transaction_log, 32'd500);
    check_eq("ok_src", {24'd0, last_src_id}, 32'h22);
    check_eq("ok_count", {16'd0, credit_count}, 32'd1);
    ack(0);

    // Backpressure: a competing request during RESP must be ignored
    send(0, 8'h33, 8'h01, 32'd1000, lat, st);
    check_eq("hold_first", balance, 32'd101500);
    req_valid = 1'b1; req_src_id = 8'h44; req_dst_id = 8'h01; req_amount = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_rvalid", {31'd0, resp_valid}, 32'd1);
      check_eq("hold_status", {30'd0, resp_status}, 32'd0);
      check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    ack(0);
    check_eq("hold_rvalid_low", {31'd0, resp_valid}, 32'd0);
    check_eq("hold_balance", balance, 32'd101500);
    check_eq("hold_count", {16'd0, credit_count}, 32'd2);
    check_eq("hold_src", {24'd0, last_src_id}, 32'h33);

    // Reset while in CHECK aborts the transfer
    @(negedge clk);
    req_valid = 1'b1; req_src_id = 8'h55; req_dst_id = 8'h01; req_amount = 32'd700;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_rvalid", {31'd0, resp_valid}, 32'd0);
    check_eq("abort_balance", balance, 32'd100000);
    check_eq("abort_count", {16'd0, credit_count}, 32'd0);
    check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 check_eq("abort_no_resp", {31'd0, resp_valid}, 32'd0);

    // Preload the counter just below wrap
    force dut.credit_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.credit_count_q;
    @(negedge clk);
    check_eq("wrap_pre", {16'd0, credit_count}, 32'h0000_FFFF);
    send(0, 8'h66, 8'h01, 32'd10, lat, st);
    check_eq("wrap_status", {30'd0, st}, 32'd0);
    check_eq("wrap_count", {16'd0, credit_count}, 32'd0);
    check_eq("wrap_balance", balance, 32'd100010);
    ack(0);

    send(1, 8'h77, 8'h01, 32'h0000_00FF, lat, st);
    check_eq("max_status", {30'd0, st}, 32'd0);
    check_eq("max_balance", balance_h, 32'hFFFF_FFFF);
    ack(1);
    send(1, 8'h78, 8'h01, 32'd1, lat, st);
    check_eq("ovf_status", {30'd0, st}, 32'd2);
    check_eq("ovf_balance", balance_h, 32'hFFFF_FFFF);
    check_eq("ovf_count", {16'd0, credit_count_h}, 32'd1);
    check_eq("ovf_log", transaction_log_h, 32'h0000_00FF);
    ack(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
